if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction fetch stage for the OpenMIPS core. It owns the program counter and drives the instruction ROM's chip-enable/address port, and it captures each acknowledged instruction word into a small prefetch queue. It presents the queue head, as a PC/instruction pair, to the IF/ID register with a valid/ready handshake. Branch and exception redirects from downstream flush the queue and restart fetching at the new target.

## Interface
- `QDEPTH`, 4: prefetch queue entries; must be a power of two and at least 2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset; 0 = reset asserted.
- `redirect_i` in 1: flush the queue and restart fetching at `redirect_pc_i`.
- `redirect_pc_i` in 32 (`InstAddrBus`): redirect target; bits [1:0] are ignored and forced to 0.
- `rom_ce_o` out 1: ROM chip enable (`ChipEnable`/`ChipDisable`).
- `rom_addr_o` out 32: fetch address, always equal to `fetch_pc`.
- `rom_inst_i` in 32 (`InstBus`): ROM data.
- `rom_ack_i` in 1: ROM data valid for the current request.
- `id_ready_i` in 1: IF/ID accepts the head entry this cycle.
- `if_valid_o` out 1: the head entry is valid.
- `if_pc_o` out 32: head entry PC.
- `if_inst_o` out 32: head entry instruction.

## Operation
- FSM states are S_BOOT, S_FETCH and S_FULL. Reset puts the FSM in S_BOOT.
  - S_BOOT → S_FETCH unconditionally on the first edge after reset releases.
  - S_FETCH → S_FULL when a push with no pop makes count == QDEPTH.
  - S_FULL → S_FETCH on any pop.
  - A redirect forces S_FETCH from any non-boot state.
- `rom_ce_o` = 1 only in S_FETCH. Otherwise it drives `ChipDisable`.
- A request is held, with the address stable, until `rom_ack_i`. The ROM may acknowledge in the same cycle (combinational) or later.
- Push: on an edge where `rom_ce_o && rom_ack_i && !redirect_i`, the entry {`fetch_pc`, `rom_inst_i`} is written to the tail and `fetch_pc` += 4.
  - `fetch_pc` wraps from 32'hFFFF_FFFC to 0.
- Pop: on an edge where `if_valid_o && id_ready_i && !redirect_i`, the head entry is advanced.
- Push and pop in the same edge: both happen and count is unchanged. This is legal at any count below QDEPTH.
- `if_valid_o` = (count != 0).
  - `if_pc_o` and `if_inst_o` are the head entry when valid. They are 0 when the queue is empty.
- Redirect priority over push and pop:
  - On the edge where `redirect_i` = 1, count becomes 0 and both pointers reset.
  - `fetch_pc` is loaded with {`redirect_pc_i`[31:2], 2'b00}.
  - Any ack or pop in that cycle is discarded.
- Reset mid-operation: the queue empties immediately (asynchronously). `fetch_pc` becomes `RESET_PC` and the FSM returns to S_BOOT.

## Timing
- Reset values of every output:
  - `rom_ce_o` = 0
  - `rom_addr_o` = `RESET_PC`
  - `if_valid_o` = 0
  - `if_pc_o` = 0
  - `if_inst_o` = 0
- After `rst` rises:
  - Edge 1 moves the FSM to S_FETCH; `rom_ce_o` is high in the following cycle.
  - With a same-cycle ack, edge 2 pushes the first word.
  - `if_valid_o` is high after edge 2.
- Throughput is one instruction per cycle when the ROM acknowledges every cycle and `id_ready_i` is held high.
- Redirect penalty: the target word enters the queue at the edge after the redirect edge. `if_valid_o` is therefore low for exactly one cycle when the ROM acknowledges in the same cycle.
- `rom_ce_o` and `if_valid_o` are decoded from registered state only. There is no combinational path from `id_ready_i` or `rom_ack_i` to `rom_ce_o`.

## Structure
- Take bus widths and constants from `defines.v`: `InstAddrBus`, `InstBus`, `ZeroWord`, `ChipEnable`, `ChipDisable`.
- Add `IfQDepth` and `IfQDepthLog2` to `defines.v`.
- One sub-module, `if_queue`:
  - synchronous FIFO of width 64 ({pc, inst}) and depth QDEPTH;
  - provides push, pop, flush, count, full and empty;
  - pointers are QDEPTHLog2+1 bits wide.
- The top level contains the FSM, `fetch_pc` and the ROM port.

## Test plan
- Reset release, ROM acknowledges every cycle, `id_ready_i` = 1 → `rom_addr_o` sequence is 0, 4, 8, 12; from edge 2 onward `if_pc_o` follows 0, 4, 8 one per cycle, with `if_inst_o` matching ROM words 0, 1, 2.
- `id_ready_i` = 0 for 10 cycles → count saturates at 4 and `rom_ce_o` drops (S_FULL) with `rom_addr_o` = 16. A single `id_ready_i` pulse pops PC 0, and `rom_ce_o` returns the next cycle.
- Redirect to 32'h0000_0103 while the queue holds 3 entries → `if_valid_o` is low for one cycle, then `if_pc_o` = 32'h100. The ack that arrived in the redirect cycle is not enqueued.
- ROM acknowledges only every 3rd cycle → `rom_addr_o` holds for 3 cycles per word, and there are no duplicate or missing PCs at the output.
- Start with `fetch_pc` at 32'hFFFF_FFF8 via redirect → the output shows PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `rst` low mid-stream, asynchronously between edges → all outputs take their reset values immediately, and after release fetching restarts at `RESET_PC`.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: bus widths, chip-enable levels, queue depth and FSM state type shared by the fetch stage.
package if_fetch_unit_pkg;
  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS = 32;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam int IF_QDEPTH = 4;
  localparam int IF_QDEPTH_LOG2 = 2;
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_FULL} fetch_state_t;
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_fetch_unit_queue.sv
// if_queue: prefetch FIFO of {pc, inst} entries with flush; pointers carry one extra wrap bit.
module if_queue
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = IF_QDEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [63:0]   i_wdata,
  output logic [63:0]   o_rdata,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);
  logic [63:0] r_mem [DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd + 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr[AW-1:0]] <= i_wdata;
  end
  assign o_count = r_wr - r_rd;
  assign o_full = o_count == (AW+1)'(DEPTH);
  assign o_empty = o_count == '0;
  assign o_rdata = r_mem[r_rd[AW-1:0]];
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the PC, drives the instruction ROM port and hands queued {pc, inst} pairs to IF/ID.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int QDEPTH = IF_QDEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_rom_ce,
  output logic [31:0] o_rom_addr,
  input  logic [31:0] i_rom_inst,
  input  logic        i_rom_ack,
  input  logic        i_id_ready,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_inst
);
  localparam int QAW = $clog2(QDEPTH);
  localparam logic [QAW:0] Q_LAST = (QAW+1)'(QDEPTH - 1);
  fetch_state_t r_state;
  fetch_state_t w_next;
  logic [31:0] r_fetch_pc;
  logic [63:0] w_head;
  logic [QAW:0] w_count;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  assign o_rom_ce = (r_state == S_FETCH) ? CHIP_ENABLE : CHIP_DISABLE;
  assign o_rom_addr = r_fetch_pc;
  assign o_if_valid = !w_empty;
  assign o_if_pc = o_if_valid ? w_head[63:32] : ZERO_WORD;
  assign o_if_inst = o_if_valid ? w_head[31:0] : ZERO_WORD;
  // Redirect wins over both queue ports so a stale ack or pop in that cycle is dropped.
  assign w_push = o_rom_ce && i_rom_ack && !i_redirect && !w_full;
  assign w_pop = o_if_valid && i_id_ready && !i_redirect;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_BOOT: w_next = S_FETCH;
      S_FETCH: w_next = (w_push && !w_pop && w_count == Q_LAST) ? S_FULL : S_FETCH;
      S_FULL: w_next = w_pop ? S_FETCH : S_FULL;
      default: w_next = S_BOOT;
    endcase
    if (i_redirect && r_state != S_BOOT) w_next = S_FETCH;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_BOOT;
    else r_state <= w_next;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_fetch_pc <= RESET_PC;
    else if (i_redirect) r_fetch_pc <= align_word(i_redirect_pc);
    else if (w_push) r_fetch_pc <= r_fetch_pc + 32'd4;
  end
  if_queue #(.DEPTH(QDEPTH), .AW(QAW)) u_queue (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_flush(i_redirect),
    .i_wdata({r_fetch_pc, i_rom_inst}),
    .o_rdata(w_head),
    .o_count(w_count),
    .o_full (w_full),
    .o_empty(w_empty)
  );
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: table vectors, corner sequences and random traffic checked against a queue-based fetch model.
module tb_if_fetch_unit;
  localparam int QD = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic rom_ack = 1'b0;
  logic id_ready = 1'b0;
  logic rom_ce;
  logic if_valid;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  int n_chk = 0;
  int n_err = 0;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  typedef struct {
    logic rd;
    logic [31:0] rpc;
    logic ack;
    logic rdy;
    logic e_ce;
    logic [31:0] e_addr;
    logic e_valid;
    logic [31:0] e_pc;
  } vec_t;
  ent_t mq[$];
  logic m_boot;
  logic [31:0] m_pc;
  vec_t tbl[6];
  logic [31:0] dexp[3];
  always #5 clk = ~clk;
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ (a >> 2);
  endfunction
  assign rom_inst = rom_word(rom_addr);
  if_fetch_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_rom_ce(rom_ce), .o_rom_addr(rom_addr), .i_rom_inst(rom_inst), .i_rom_ack(rom_ack),
    .i_id_ready(id_ready), .o_if_valid(if_valid), .o_if_pc(if_pc), .o_if_inst(if_inst)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic model_reset();
    mq.delete();
    m_boot = 1'b0;
    m_pc = 32'h0;
  endtask
  // The ROM is enabled whenever fetching has begun and the queue has room.
  task automatic model_check();
    logic v;
    v = mq.size() != 0;
    chk("rom_ce", rom_ce, m_boot && mq.size() < QD);
    chk("rom_addr", rom_addr, m_pc);
    chk("if_valid", if_valid, v);
    chk("if_pc", if_pc, v ? mq[0].pc : 32'h0);
    chk("if_inst", if_inst, v ? mq[0].inst : 32'h0);
  endtask
  task automatic model_step();
    logic ce;
    logic v;
    ce = m_boot && mq.size() < QD;
    v = mq.size() != 0;
    if (!m_boot) m_boot = 1'b1;
    if (redirect) begin
      mq.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (v && id_ready) void'(mq.pop_front());
      if (ce && rom_ack) begin
        mq.push_back('{m_pc, rom_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask
  task automatic drive(input logic rd, input logic [31:0] rpc, input logic ack, input logic rdy);
    redirect = rd;
    redirect_pc = rpc;
    rom_ack = ack;
    id_ready = rdy;
    #1 model_check();
  endtask
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1 model_reset();
    model_check();
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h8, 1'b1, 32'h4};
    tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hC, 1'b1, 32'h8};
    tbl[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC};
    dexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ce", rom_ce, 1'b0);
    chk("rst_addr", rom_addr, 32'h0);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].rd, tbl[i].rpc, tbl[i].ack, tbl[i].rdy);
      chk("tbl_ce", rom_ce, tbl[i].e_ce);
      chk("tbl_addr", rom_addr, tbl[i].e_addr);
      chk("tbl_valid", if_valid, tbl[i].e_valid);
      chk("tbl_pc", if_pc, tbl[i].e_pc);
      chk("tbl_inst", if_inst, tbl[i].e_valid ? rom_word(tbl[i].e_pc) : 32'h0);
      tick();
    end
    do_reset();
    repeat (10) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("full_ce", rom_ce, 1'b0);
    chk("full_addr", rom_addr, 32'h10);
    chk("full_pc", if_pc, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("unfull_ce", rom_ce, 1'b1);
    chk("unfull_pc", if_pc, 32'h4);
    tick();
    drive(1'b1, 32'h0000_0103, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("redir_bubble", if_valid, 1'b0);
    chk("redir_addr", rom_addr, 32'h100);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk("redir_valid", if_valid, 1'b1);
    chk("redir_pc", if_pc, 32'h100);
    tick();
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, 32'h0, (i % 3) == 2, 1'b1);
      tick();
    end
    drive(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0);
    tick();
    repeat (3) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      chk("wrap_pc", if_pc, dexp[k]);
      tick();
    end
    repeat (3) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_ce", rom_ce, 1'b0);
    chk("async_addr", rom_addr, 32'h0);
    chk("async_valid", if_valid, 1'b0);
    chk("async_pc", if_pc, 32'h0);
    chk("async_inst", if_inst, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk("restart_ce", rom_ce, 1'b1);
    chk("restart_addr", rom_addr, 32'h0);
    tick();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 19) == 0,
            $urandom_range(0, 1) ? 32'($urandom) : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
